// File: rtl/multi_sync_pkg.sv
// Shared types and constants for multi_sync_capture: capture FSM states,
// default parameter values and the filter counter width helper.
package multi_sync_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    CAPTURE  = 2'b01,
    WAIT_LOW = 2'b10
  } cap_state_t;

  localparam int DEF_CHANNELS   = 4;
  localparam int DEF_STAGES     = 2;
  localparam int DEF_FILTER_CNT = 3;
  localparam int DEF_BITS_WIDTH = 5;

  function automatic int cnt_width(input int fc);
    return (fc < 1) ? 1 : $clog2(fc + 1);
  endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// One level channel: STAGES-deep synchronizer, persistence filter and
// registered rise/fall pulses aligned with the filtered level change.
module sync_filter_ch
  import multi_sync_pkg::*;
#(
  parameter int STAGES     = DEF_STAGES,
  parameter int FILTER_CNT = DEF_FILTER_CNT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_raw,
  output logic sync_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int CW = cnt_width(FILTER_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CNT - 1);

  logic [STAGES-1:0] r_sync;
  logic [CW-1:0]     r_cnt;
  logic              r_level;
  logic              r_rise;
  logic              r_fall;
  logic              w_s;

  assign w_s = r_sync[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], async_in};
    end
  end

  // The level only follows the synchronized input once it has differed for
  // FILTER_CNT consecutive cycles; the pulses update on that same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_s == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= w_s;
        r_cnt   <= '0;
        r_rise  <= w_s;
        r_fall  <= ~w_s;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign sync_raw   = w_s;
  assign sync_out   = r_level;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;

endmodule

// File: rtl/multi_sync_capture.sv
// Multi-channel level synchronizer plus strobe-qualified bus capture FSM.
// Optional pending/overrun tracking is enabled by MULTI_SYNC_OVERRUN_EN.
module multi_sync_capture
  import multi_sync_pkg::*;
#(
  parameter int CHANNELS   = DEF_CHANNELS,
  parameter int STAGES     = DEF_STAGES,
  parameter int FILTER_CNT = DEF_FILTER_CNT,
  parameter int BITS_WIDTH = DEF_BITS_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CHANNELS-1:0]   async_in,
  output logic [CHANNELS-1:0]   sync_out,
  output logic [CHANNELS-1:0]   rise_pulse,
  output logic [CHANNELS-1:0]   fall_pulse,
  input  logic                  strobe_async,
  input  logic [BITS_WIDTH-1:0] data_async,
  output logic [BITS_WIDTH-1:0] data_out,
  output logic                  data_valid
`ifdef MULTI_SYNC_OVERRUN_EN
  ,
  input  logic                  data_ack,
  output logic                  overrun
`endif
);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic w_unused_raw;
      sync_filter_ch #(
        .STAGES    (STAGES),
        .FILTER_CNT(FILTER_CNT)
      ) u_ch (
        .clk       (clk),
        .rst_n     (rst_n),
        .async_in  (async_in[gi]),
        .sync_raw  (w_unused_raw),
        .sync_out  (sync_out[gi]),
        .rise_pulse(rise_pulse[gi]),
        .fall_pulse(fall_pulse[gi])
      );
    end
  endgenerate

  // Strobe is taken straight off the synchronizer tap, bypassing the filter.
  logic w_ss;
  logic w_unused_strobe_lvl;
  logic w_unused_strobe_rise;
  logic w_unused_strobe_fall;

  sync_filter_ch #(
    .STAGES    (STAGES),
    .FILTER_CNT(1)
  ) u_strobe (
    .clk       (clk),
    .rst_n     (rst_n),
    .async_in  (strobe_async),
    .sync_raw  (w_ss),
    .sync_out  (w_unused_strobe_lvl),
    .rise_pulse(w_unused_strobe_rise),
    .fall_pulse(w_unused_strobe_fall)
  );

  cap_state_t            r_state;
  cap_state_t            w_state_next;
  logic                  w_capture;
  logic [BITS_WIDTH-1:0] r_data_out;
  logic                  r_data_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ss) begin
          w_state_next = CAPTURE;
          w_capture    = 1'b1;
        end
      end
      CAPTURE:  w_state_next = WAIT_LOW;
      WAIT_LOW: if (!w_ss) w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  // The word is loaded on entry to CAPTURE so data_out and data_valid
  // change together for the whole CAPTURE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_data_valid <= w_capture;
      if (w_capture) r_data_out <= data_async;
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;

`ifdef MULTI_SYNC_OVERRUN_EN
  logic r_pending;
  logic r_overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else if (r_state == CAPTURE) begin
      r_pending <= 1'b1;
      if (r_pending && !data_ack) r_overrun <= 1'b1;
    end else if (data_ack) begin
      r_pending <= 1'b0;
    end
  end

  assign overrun = r_overrun;
`endif

endmodule

// File: tb/tb_multi_sync_capture.sv
// Scoreboard bench for multi_sync_capture: stimulus pushes expected pulse and
// capture events, a negedge monitor pops and compares them as they appear.
module tb_multi_sync_capture;
  import multi_sync_pkg::*;

  localparam int CH = 4;
  localparam int ST = 2;
  localparam int FC = 3;
  localparam int BW = 5;
  localparam int LVL_LAT = ST + FC;
  localparam int CAP_LAT = ST + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] async_in = '0;
  logic [CH-1:0] sync_out;
  logic [CH-1:0] rise_pulse;
  logic [CH-1:0] fall_pulse;
  logic          strobe_async = 1'b0;
  logic [BW-1:0] data_async = '0;
  logic [BW-1:0] data_out;
  logic          data_valid;
`ifdef MULTI_SYNC_OVERRUN_EN
  logic          data_ack = 1'b0;
  logic          overrun;
`endif

  multi_sync_capture #(
    .CHANNELS  (CH),
    .STAGES    (ST),
    .FILTER_CNT(FC),
    .BITS_WIDTH(BW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .async_in    (async_in),
    .sync_out    (sync_out),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .strobe_async(strobe_async),
    .data_async  (data_async),
    .data_out    (data_out),
    .data_valid  (data_valid)
`ifdef MULTI_SYNC_OVERRUN_EN
    ,
    .data_ack    (data_ack),
    .overrun     (overrun)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] lvl;
  } pulse_t;

  typedef struct {
    int            cyc;
    logic [BW-1:0] data;
  } cap_t;

  pulse_t pulse_q[$];
  cap_t   cap_q[$];

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_pulse(input logic [CH-1:0] r, input logic [CH-1:0] f, input logic [CH-1:0] l);
    pulse_t p;
    p.cyc  = cyc + LVL_LAT;
    p.rise = r;
    p.fall = f;
    p.lvl  = l;
    pulse_q.push_back(p);
  endtask

  task automatic push_cap(input logic [BW-1:0] d);
    cap_t c;
    c.cyc  = cyc + CAP_LAT;
    c.data = d;
    cap_q.push_back(c);
  endtask

  // Monitor: every pulse or data_valid seen must match the head of its queue.
  always @(negedge clk) begin
    if ((rise_pulse | fall_pulse) != '0) begin
      if (pulse_q.size() == 0) begin
        check("unexpected_pulse", {24'd0, rise_pulse, fall_pulse}, 32'd0);
      end else begin
        pulse_t p;
        p = pulse_q.pop_front();
        $display("pulse: cycle %0d rise=%b fall=%b sync_out=%b", cyc, rise_pulse, fall_pulse, sync_out);
        check("pulse_cycle", cyc, p.cyc);
        check("rise_pulse", rise_pulse, p.rise);
        check("fall_pulse", fall_pulse, p.fall);
        check("sync_out_at_pulse", sync_out, p.lvl);
      end
    end
    if (data_valid) begin
      if (cap_q.size() == 0) begin
        check("unexpected_data_valid", data_valid, 1'b0);
      end else begin
        cap_t c;
        c = cap_q.pop_front();
        $display("capture: cycle %0d data_out=0x%0h", cyc, data_out);
        check("capture_cycle", cyc, c.cyc);
        check("capture_data", data_out, c.data);
      end
    end
  end

  task automatic strobe_word(input logic [BW-1:0] d, input int high_cycles);
    data_async   = d;
    strobe_async = 1'b1;
    push_cap(d);
    wait_cyc(high_cycles);
    strobe_async = 1'b0;
  endtask

  initial begin
    // Reset held with inputs toggling: everything must stay cleared.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      async_in     = CH'($urandom);
      strobe_async = 1'($urandom);
      data_async   = BW'($urandom);
    end
    #1;
    check("rst_sync_out", sync_out, 0);
    check("rst_rise", rise_pulse, 0);
    check("rst_fall", fall_pulse, 0);
    check("rst_data_out", data_out, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_state", dut.r_state, IDLE);
    @(negedge clk);
    async_in = '0; strobe_async = 1'b0; data_async = '0;
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(6);

    // Clean rise and fall on channel 0.
    async_in[0] = 1'b1;
    push_pulse(4'b0001, 4'b0000, 4'b0001);
    wait_cyc(10);
    check("ch0_high_held", sync_out, 4'b0001);
    async_in[0] = 1'b0;
    push_pulse(4'b0000, 4'b0001, 4'b0000);
    wait_cyc(10);

    // Two-cycle glitch on channel 2 is swallowed.
    async_in[2] = 1'b1;
    wait_cyc(2);
    async_in[2] = 1'b0;
    wait_cyc(10);
    check("glitch_filtered", sync_out, 4'b0000);

    // Simultaneous rise on channels 1 and 3.
    async_in = 4'b1010;
    push_pulse(4'b1010, 4'b0000, 4'b1010);
    wait_cyc(10);

    // Single capture, then the bus changes and data_out must hold.
    strobe_word(5'h15, 6);
    data_async = 5'h00;
    wait_cyc(10);
    check("data_out_held", data_out, 5'h15);

    // Long strobe yields one capture; a short gap then a second capture.
    strobe_word(5'h1B, 20);
    wait_cyc(4);
    data_async   = 5'h0A;
    strobe_async = 1'b1;
    push_cap(5'h0A);
    wait_cyc(6);
    check("wait_low_state", dut.r_state, WAIT_LOW);
    check("data_out_second", data_out, 5'h0A);

    // Asynchronous reset in WAIT_LOW clears outputs without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_sync_out", sync_out, 0);
    check("midrst_data_out", data_out, 0);
    check("midrst_data_valid", data_valid, 0);
    check("midrst_state", dut.r_state, IDLE);
    @(negedge clk);
    strobe_async = 1'b0; async_in = '0; data_async = '0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(8);

`ifdef MULTI_SYNC_OVERRUN_EN
    check("ovr_after_reset", overrun, 1'b0);
    strobe_word(5'h03, 5);
    wait_cyc(5);
    strobe_word(5'h04, 5);
    wait_cyc(5);
    check("ovr_set", overrun, 1'b1);
    wait_cyc(10);
    check("ovr_sticky", overrun, 1'b1);

    rst_n = 1'b0;
    #1;
    check("ovr_reset_clears", overrun, 1'b0);
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(4);
    strobe_word(5'h05, 5);
    wait_cyc(5);
    data_async   = 5'h06;
    strobe_async = 1'b1;
    push_cap(5'h06);
    wait_cyc(CAP_LAT);
    check("ack_in_capture_cycle", data_valid, 1'b1);
    data_ack = 1'b1;
    wait_cyc(1);
    data_ack = 1'b0;
    wait_cyc(4);
    strobe_async = 1'b0;
    wait_cyc(6);
    check("ovr_not_set_with_ack", overrun, 1'b0);
`endif

    for (int i = 0; i < 40 && (pulse_q.size() != 0 || cap_q.size() != 0); i++) @(negedge clk);
    check("pulse_q_drained", pulse_q.size(), 0);
    check("cap_q_drained", cap_q.size(), 0);
    wait_cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multi_sync_capture.md
Name: multi_sync_capture

Overview:
- Parametrised successor to the single-bus recirculation synchronizer.
- Brings CHANNELS asynchronous level inputs and one strobe-qualified data bus into a single clock domain.
- Each level channel gets an N-stage synchronizer, a glitch filter and rise/fall pulse generation.
- The data bus is captured by a small FSM on the synchronized strobe. The block sits at the boundary between external/async sources and core logic.

Parameters:
- CHANNELS, 4, number of async level channels (>=1)
- STAGES, 2, synchronizer flops per input, strobe included (>=2)
- FILTER_CNT, 3, consecutive cycles a changed level must persist before sync_out follows (>=1; 1 = no filtering)
- BITS_WIDTH, 5, captured data bus width (>=1)

Ports:
- clk  in  1  single clock for all logic
- rst_n  in  1  asynchronous active-low reset
- async_in  in  CHANNELS  asynchronous level inputs
- sync_out  out  CHANNELS  synchronized, filtered levels
- rise_pulse  out  CHANNELS  one-cycle pulse on a sync_out 0->1 change
- fall_pulse  out  CHANNELS  one-cycle pulse on a sync_out 1->0 change
- strobe_async  in  1  asynchronous capture qualifier, active high
- data_async  in  BITS_WIDTH  bus, stable while strobe_async is high
- data_out  out  BITS_WIDTH  last captured word, held between captures
- data_valid  out  1  one-cycle pulse when data_out updates

Behaviour:
- Reset:
  - One clock domain (clk); reset is asynchronous, active-low (rst_n).
  - rst_n low immediately clears all sync flops, counters, sync_out, both pulse buses, data_out, data_valid and overrun, and forces the FSM to IDLE.
  - Reset asserted mid-operation (any state, any counter value) aborts it with no pulse emitted.
  - rst_n deassertion is synchronized by the system; the block requires it.
- Sync chain: per channel, async_in -> STAGES flops; the last stage is s[i].
- Filter, per channel, counter width clog2(FILTER_CNT+1):
  - If s[i]==sync_out[i]: counter cleared.
  - Else: counter increments. When counter==FILTER_CNT-1 and s[i] still differs, sync_out[i] <= s[i] and the counter clears on the next edge.
  - Any return to equality before then clears the counter. No change and no pulse for glitches shorter than FILTER_CNT cycles after sync.
- Latency: a clean input change reaches sync_out exactly STAGES+FILTER_CNT clocks after the first clk edge that samples it.
- Pulses: rise_pulse/fall_pulse are registered and high in exactly the cycle sync_out shows its new value, for one cycle only. Channels are independent; simultaneous changes on several channels pulse together.
- Capture FSM (strobe via its own STAGES chain -> ss):
  - IDLE: ss==1 -> CAPTURE.
  - CAPTURE, one cycle: data_out <= data_async, data_valid=1, -> WAIT_LOW.
  - WAIT_LOW: ss==0 -> IDLE, else stay.
  - data_out recirculates (holds) in every state except CAPTURE.
  - Latency: data_valid is high STAGES+1 clocks after the strobe is first sampled high.
  - Protocol rules: data_async stable from strobe rise until >= STAGES+2 clocks later. strobe_async low >= STAGES+1 clocks between captures.
  - A strobe held high indefinitely yields exactly one capture.
- Filtering does not apply to strobe_async.

Optional Feature:
- Macro MULTI_SYNC_OVERRUN_EN.
- With it: adds input data_ack (1 bit) and output overrun (1 bit, sticky).
  - data_ack high clears the pending flag.
  - A CAPTURE while the pending flag is set sets overrun.
  - A CAPTURE in the same cycle as data_ack does not set overrun, and pending stays set for the new word.
  - overrun clears only on reset.
- Without it: neither port exists, no pending tracking, and behaviour is otherwise identical.

Decomposition:
- Package multi_sync_pkg holds:
  - capture FSM state typedef: IDLE=2'b00, CAPTURE=2'b01, WAIT_LOW=2'b10
  - default parameter constants
  - counter-width function (clog2)
- Sub-module sync_filter_ch: one channel's sync chain, filter counter and edge-pulse logic, instantiated CHANNELS times by generate.
- The strobe chain reuses the same STAGES flop structure with FILTER_CNT=1.

Test Plan:
1. Reset (CHANNELS=4, STAGES=2, FILTER_CNT=3, BITS_WIDTH=5): drive rst_n=0 with inputs toggling -> all outputs 0, FSM IDLE. Assert rst_n mid-WAIT_LOW -> outputs clear within the same cycle, no data_valid.
2. async_in[0] 0->1 held -> sync_out[0]=1 exactly 5 clocks after first sampling edge, rise_pulse[0] high for that single cycle. Release -> fall_pulse[0] 5 clocks later.
3. async_in[2] high for 2 clocks then low -> sync_out[2] stays 0, no pulses. Then async_in[1] and async_in[3] rise together -> both rise_pulse bits in the same cycle.
4. data_async=5'h15, strobe_async high 6 clocks, then data_async=5'h00 -> single data_valid 3 clocks after strobe sampled, data_out=5'h15 held afterwards.
5. strobe_async high 20 clocks -> exactly one data_valid. Low 4 clocks, then high with data_async=5'h0A -> second data_valid, data_out=5'h0A.
6. MULTI_SYNC_OVERRUN_EN:
   - Two captures with no data_ack -> overrun=1, held until reset.
   - Repeat with data_ack pulsed in the second CAPTURE cycle -> overrun stays 0.
